// File: rtl/kmer_pkg.sv
// Shared types, geometry constants and helpers for the k-mer reassembly block.
// The placement sub-module and the top both import this package.
package kmer_pkg;

  localparam int READ_W     = 512;
  localparam int BASES      = 256;
  localparam int KMER_BASES = 45;
  localparam int KMER_W     = 2 * KMER_BASES;
  localparam int POS_W      = 8;
  localparam int REC_W      = POS_W + KMER_W;
  localparam int CNT_W      = 9;
  localparam int BASE_SKIP  = 4;
  localparam int MAX_B      = 207;

  typedef struct packed {
    logic [POS_W-1:0]  pos;
    logic [KMER_W-1:0] kmer;
  } kmer_rec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } kmer_state_t;

  // Base i lives at read bits [511-2i : 510-2i]; duplicate each cov bit onto both bits.
  function automatic logic [READ_W-1:0] cov_to_bits(input logic [BASES-1:0] cov);
    logic [READ_W-1:0] bits;
    bits = {READ_W{1'b0}};
    for (int i = 0; i < BASES; i++) begin
      bits[READ_W-1-2*i] = cov[i];
      bits[READ_W-2-2*i] = cov[i];
    end
    return bits;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/kmer_place.sv
// Combinational placement of one k-mer into read coordinates: aligned data,
// bit-level write mask, base-level coverage mask and the range flag.
module kmer_place
  import kmer_pkg::*;
(
  input  logic [POS_W-1:0]  i_pos,
  input  logic [KMER_W-1:0] i_kmer,
  output logic [READ_W-1:0] o_data,
  output logic [READ_W-1:0] o_wmask,
  output logic [BASES-1:0]  o_bmask,
  output logic              o_in_range
);

  localparam int TAIL_W = READ_W - KMER_W - 2*BASE_SKIP;

  localparam logic [READ_W-1:0] MASK_AT_B0 =
    {{(2*BASE_SKIP){1'b0}}, {KMER_W{1'b1}}, {TAIL_W{1'b0}}};
  localparam logic [BASES-1:0] BASE_ONES =
    {{(BASES-KMER_BASES){1'b0}}, {KMER_BASES{1'b1}}};

  logic [POS_W-1:0] w_b;
  logic [8:0]       w_bit_sh;
  logic [8:0]       w_base_sh;

  // pos+1 wraps in 8 bits, so pos=255 lands at b=0
  assign w_b       = i_pos + 8'd1;
  assign w_bit_sh  = {w_b, 1'b0};
  assign w_base_sh = {1'b0, w_b} + 9'd4;

  assign o_data     = {{(2*BASE_SKIP){1'b0}}, i_kmer, {TAIL_W{1'b0}}} >> w_bit_sh;
  assign o_wmask    = MASK_AT_B0 >> w_bit_sh;
  assign o_bmask    = BASE_ONES << w_base_sh;
  assign o_in_range = (w_b <= POS_W'(MAX_B));

endmodule

// File: rtl/kmer_assemble.sv
// Rebuilds a 256-base read from a stream of {pos, k-mer} records written over
// the original read, reporting coverage and record/drop/conflict statistics.
module kmer_assemble
  import kmer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [READ_W-1:0] read_in,
  input  logic              kmer_valid,
  output logic              kmer_ready,
  input  logic [REC_W-1:0]  kmer_in,
  input  logic              kmer_last,
  output logic [READ_W-1:0] read_out,
  output logic [BASES-1:0]  cov_out,
  output logic [CNT_W-1:0]  rec_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              out_valid,
  input  logic              out_ready
);

  kmer_state_t       r_state;
  kmer_state_t       w_state_next;
  logic              r_kmer_ready;
  logic              r_out_valid;
  logic [READ_W-1:0] r_buf;
  logic [BASES-1:0]  r_cov;
  logic [CNT_W-1:0]  r_rec_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_conf_cnt;

  kmer_rec_t         w_rec;
  logic              w_accept;
  logic [READ_W-1:0] w_data;
  logic [READ_W-1:0] w_wmask;
  logic [BASES-1:0]  w_bmask;
  logic              w_in_range;
  logic              w_conflict;

  assign w_rec    = kmer_in;
  assign w_accept = kmer_valid & r_kmer_ready;

  kmer_place u_place (
    .i_pos      (w_rec.pos),
    .i_kmer     (w_rec.kmer),
    .o_data     (w_data),
    .o_wmask    (w_wmask),
    .o_bmask    (w_bmask),
    .o_in_range (w_in_range)
  );

  // A covered base whose stored value differs from the incoming one is a conflict
  assign w_conflict = |((r_buf ^ w_data) & w_wmask & cov_to_bits(r_cov));

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = COLLECT;
        end else begin
          w_state_next = IDLE;
        end
      end
      COLLECT: begin
        if (w_accept && kmer_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = COLLECT;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register and handshake flags, registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_kmer_ready <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_kmer_ready <= (w_state_next == COLLECT);
      r_out_valid  <= (w_state_next == DONE);
    end
  end

  // Read buffer, coverage and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf      <= {READ_W{1'b0}};
      r_cov      <= {BASES{1'b0}};
      r_rec_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
      r_conf_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == IDLE) && start) begin
      r_buf      <= read_in;
      r_cov      <= {BASES{1'b0}};
      r_rec_cnt  <= {CNT_W{1'b0}};
      r_drop_cnt <= {CNT_W{1'b0}};
      r_conf_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      if (w_in_range) begin
        r_buf     <= (r_buf & ~w_wmask) | w_data;
        r_cov     <= r_cov | w_bmask;
        r_rec_cnt <= sat_inc(r_rec_cnt);
        if (w_conflict) begin
          r_conf_cnt <= sat_inc(r_conf_cnt);
        end else begin
          r_conf_cnt <= r_conf_cnt;
        end
      end else begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end else begin
      r_buf <= r_buf;
    end
  end

  assign kmer_ready   = r_kmer_ready;
  assign out_valid    = r_out_valid;
  assign read_out     = r_buf;
  assign cov_out      = r_cov;
  assign rec_cnt      = r_rec_cnt;
  assign drop_cnt     = r_drop_cnt;
  assign conflict_cnt = r_conf_cnt;

endmodule
